// File: rtl/pipe_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl_pkg
// Shared definitions for the pipeline stall controller: stall bus width,
// Stop/NoStop bit values, per-stage stall patterns, divider sequencer state
// encodings and a helper that merges stage requests into a stall pattern.
// No ports (package).
// ---------------------------------------------------------------------------
package pipe_stall_ctrl_pkg;

    localparam int unsigned StallBus = 6;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // Bit order, MSB..LSB: WB, MEM/WB, EX/MEM, ID/EX, IF/ID, PC.
    // A Stop followed by a NoStop on the next boundary injects a bubble.
    localparam logic [StallBus-1:0] STALL_NONE = {NoStop, NoStop, NoStop, NoStop, NoStop, NoStop};
    localparam logic [StallBus-1:0] STALL_IF   = {NoStop, NoStop, NoStop, NoStop, Stop,   Stop};
    localparam logic [StallBus-1:0] STALL_ID   = {NoStop, NoStop, NoStop, Stop,   Stop,   Stop};
    localparam logic [StallBus-1:0] STALL_EX   = {NoStop, NoStop, Stop,   Stop,   Stop,   Stop};
    localparam logic [StallBus-1:0] STALL_MEM  = {NoStop, Stop,   Stop,   Stop,   Stop,   Stop};

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Patterns are nested, so the OR of all active patterns is the pattern of
    // the highest requesting stage.
    function automatic logic [StallBus-1:0] stall_merge(input logic if_req,
                                                        input logic id_req,
                                                        input logic ex_req,
                                                        input logic mem_req);
        logic [StallBus-1:0] s;
        s = STALL_NONE;
        if (if_req)  s = s | STALL_IF;
        if (id_req)  s = s | STALL_ID;
        if (ex_req)  s = s | STALL_EX;
        if (mem_req) s = s | STALL_MEM;
        return s;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_div_seq.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl_div_seq
// Multi-cycle divider sequencer: launches the divider, holds EX for the
// iteration count and flags the cycle in which the result is valid.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ex_div_req      div/divu instruction present in EX
//   mem_stallreq    MEM stage stall (blocks launch, holds DONE)
//   div_go          one-cycle launch pulse (combinational)
//   div_valid       result valid (state DONE, registered)
//   div_busy        divider iterating (state BUSY, registered)
//   div_hold        EX-level stall request from the divider
// ---------------------------------------------------------------------------
module pipe_stall_ctrl_div_seq
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic ex_div_req,
    input  logic mem_stallreq,
    output logic div_go,
    output logic div_valid,
    output logic div_busy,
    output logic div_hold
);

    localparam logic [5:0] CntLast = 6'(DIV_CYCLES - 1);

    div_state_e state_q;
    logic [5:0] cnt_q;
    logic       busy_q;
    logic       valid_q;
    logic       launch;

    // No launch while MEM stalls: the MEM pattern already freezes EX.
    assign launch = (state_q == DIV_IDLE) & ex_div_req & ~mem_stallreq & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (launch) begin
                        state_q <= DIV_BUSY;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                DIV_BUSY: begin
                    if (cnt_q == CntLast) begin
                        state_q <= DIV_DONE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                DIV_DONE: begin
                    // ex_div_req is ignored here so the same instruction is
                    // never relaunched; wait for EX to be free to advance.
                    if (!mem_stallreq) begin
                        state_q <= DIV_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= DIV_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign div_go    = launch;
    assign div_busy  = busy_q;
    assign div_valid = valid_q;
    // EX is held in the launch cycle and throughout BUSY, released in DONE.
    assign div_hold  = launch | busy_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
// Central stall/sequencing controller for the 5-stage pipeline. Merges the
// IF/ID/EX/MEM stall requests into the per-boundary stall bus and sequences
// the multi-cycle divider.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   if_stallreq     instruction SRAM not ready
//   id_stallreq     load-use hazard
//   ex_stallreq     generic EX hold
//   ex_div_req      div/divu in EX
//   mem_stallreq    data SRAM not ready
//   div_go          divider launch pulse
//   div_valid       divider result valid
//   div_busy        divider iterating
//   stall           bit i set freezes boundary i
// Optional (macro PIPE_STALL_PERF_CNT_EN defined):
//   perf_stall_cycles, perf_div_cycles, perf_loaduse_cycles  32-bit counters
// ---------------------------------------------------------------------------
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned STALL_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_stallreq,
    input  logic               id_stallreq,
    input  logic               ex_stallreq,
    input  logic               ex_div_req,
    input  logic               mem_stallreq,
    output logic               div_go,
    output logic               div_valid,
    output logic               div_busy,
`ifdef PIPE_STALL_PERF_CNT_EN
    output logic [31:0]        perf_stall_cycles,
    output logic [31:0]        perf_div_cycles,
    output logic [31:0]        perf_loaduse_cycles,
`endif
    output logic [STALL_W-1:0] stall
);

    logic                div_hold;
    logic                ex_req;
    logic [StallBus-1:0] stall_raw;

    pipe_stall_ctrl_div_seq #(
        .DIV_CYCLES(DIV_CYCLES)
    ) u_div_seq (
        .clk         (clk),
        .rst         (rst),
        .ex_div_req  (ex_div_req),
        .mem_stallreq(mem_stallreq),
        .div_go      (div_go),
        .div_valid   (div_valid),
        .div_busy    (div_busy),
        .div_hold    (div_hold)
    );

    assign ex_req    = ex_stallreq | div_hold;
    assign stall_raw = stall_merge(if_stallreq, id_stallreq, ex_req, mem_stallreq);
    // Pipeline registers are being reset too, so no stall is needed in reset.
    assign stall     = rst ? '0 : STALL_W'(stall_raw);

`ifdef PIPE_STALL_PERF_CNT_EN
    logic loaduse_top;

    assign loaduse_top = id_stallreq & ~ex_req & ~mem_stallreq;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles   <= '0;
            perf_div_cycles     <= '0;
            perf_loaduse_cycles <= '0;
        end else begin
            if (stall[0])    perf_stall_cycles   <= perf_stall_cycles + 32'd1;
            if (div_busy)    perf_div_cycles     <= perf_div_cycles + 32'd1;
            if (loaduse_top) perf_loaduse_cycles <= perf_loaduse_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_stall_ctrl
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a timestamp-based model.
// ---------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

    localparam int N = 32;

    logic       clk = 1'b0;
    logic       rst, if_stallreq, id_stallreq, ex_stallreq, ex_div_req, mem_stallreq;
    logic       div_go, div_valid, div_busy;
    logic [5:0] stall;
`ifdef PIPE_STALL_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_div_cycles, perf_loaduse_cycles;
    logic [31:0] cap_ps, cap_pd, cap_pl;
`endif

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .DIV_CYCLES(N),
        .STALL_W   (6)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .if_stallreq        (if_stallreq),
        .id_stallreq        (id_stallreq),
        .ex_stallreq        (ex_stallreq),
        .ex_div_req         (ex_div_req),
        .mem_stallreq       (mem_stallreq),
        .div_go             (div_go),
        .div_valid          (div_valid),
        .div_busy           (div_busy),
`ifdef PIPE_STALL_PERF_CNT_EN
        .perf_stall_cycles  (perf_stall_cycles),
        .perf_div_cycles    (perf_div_cycles),
        .perf_loaduse_cycles(perf_loaduse_cycles),
`endif
        .stall              (stall)
    );

    int total = 0;
    int bad   = 0;

    // Model: cycle number, launch timestamp of the running division (-1 if
    // none) and a flag for the result-valid phase.
    int          cyc     = 0;
    int          launch  = -1;
    bit          done_ph = 1'b0;
    int unsigned m_ps = 0, m_pd = 0, m_pl = 0;

    logic       cap_go, cap_busy, cap_valid;
    logic [5:0] cap_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [5:0] pattern(input bit m, input bit e, input bit i, input bit f);
        if (m) return 6'b011111;
        if (e) return 6'b001111;
        if (i) return 6'b000111;
        if (f) return 6'b000011;
        return 6'b000000;
    endfunction

    // One clock cycle: drive, compare mid-cycle, advance model at the edge.
    task automatic cycle(input bit r, input bit f, input bit i, input bit e,
                         input bit dr, input bit m);
        bit         m_go, m_busy, m_valid, hold;
        logic [5:0] m_stall;
        rst = r; if_stallreq = f; id_stallreq = i; ex_stallreq = e;
        ex_div_req = dr; mem_stallreq = m;
        #3;
        m_busy  = (launch >= 0) && (cyc > launch) && (cyc <= launch + N);
        m_valid = done_ph;
        m_go    = !r && (launch < 0) && !done_ph && dr && !m;
        hold    = m_go || m_busy;
        m_stall = r ? 6'b000000 : pattern(m, e || hold, i, f);
        cap_go = div_go; cap_busy = div_busy; cap_valid = div_valid; cap_stall = stall;
        check("div_go", {31'd0, div_go}, {31'd0, m_go});
        check("div_busy", {31'd0, div_busy}, {31'd0, m_busy});
        check("div_valid", {31'd0, div_valid}, {31'd0, m_valid});
        check("stall", {26'd0, stall}, {26'd0, m_stall});
`ifdef PIPE_STALL_PERF_CNT_EN
        cap_ps = perf_stall_cycles; cap_pd = perf_div_cycles; cap_pl = perf_loaduse_cycles;
        check("perf_stall_cycles", perf_stall_cycles, m_ps);
        check("perf_div_cycles", perf_div_cycles, m_pd);
        check("perf_loaduse_cycles", perf_loaduse_cycles, m_pl);
`endif
        @(posedge clk);
        if (r) begin
            launch = -1; done_ph = 1'b0;
            m_ps = 0; m_pd = 0; m_pl = 0;
        end else begin
            m_ps += int'(m_stall[0]);
            m_pd += int'(m_busy);
            m_pl += int'(i && !(e || hold) && !m);
            if (m_go) launch = cyc;
            else if (m_busy && cyc == launch + N) begin
                launch = -1; done_ph = 1'b1;
            end else if (done_ph && !m) done_ph = 1'b0;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0, 0);
    endtask

    logic [3:0] req_tab [7] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b0101, 4'b1010};
    logic [5:0] exp_tab [7] = '{6'b000011, 6'b000111, 6'b001111, 6'b011111,
                                6'b000000, 6'b011111, 6'b001111};

    initial begin
        int n_go, n_busy, n_st, n_v, n_ms;
        logic [3:0] rq;
        bit dr_r;

        rst = 1'b1; if_stallreq = 0; id_stallreq = 0; ex_stallreq = 0;
        ex_div_req = 0; mem_stallreq = 0;
        @(posedge clk); #1;

        // Reset state: registered outputs cleared after the reset edge.
        cycle(1, 0, 0, 0, 1, 0);
        check("reset_outputs", {28'd0, cap_go, cap_busy, cap_valid, |cap_stall}, 32'd0);

        // Single and combined requests, no divider activity.
        for (int k = 0; k < 7; k++) begin
            rq = req_tab[k];
            cycle(0, rq[3], rq[2], rq[1], 0, rq[0]);
            check("req_pattern", {26'd0, cap_stall}, {26'd0, exp_tab[k]});
        end

        // Full divide with ex_div_req held through DONE.
        do_reset();
        n_go = 0; n_busy = 0; n_st = 0;
        for (int k = 0; k < 34; k++) begin
            cycle(0, 0, 0, 0, 1, 0);
            if (k == 0) check("div_go_at_T", {31'd0, cap_go}, 32'd1);
            n_go += int'(cap_go); n_busy += int'(cap_busy);
            if (k <= 32 && cap_stall == 6'b001111) n_st++;
            if (k == 33) begin
                check("div_valid_T33", {31'd0, cap_valid}, 32'd1);
                check("stall_T33", {26'd0, cap_stall}, 32'd0);
            end
        end
        check("div_go_count", n_go, 1);
        check("div_busy_count", n_busy, 32);
        check("ex_stall_count", n_st, 33);
        cycle(0, 0, 0, 0, 0, 0);
        check("idle_after_done", {29'd0, cap_go, cap_busy, cap_valid}, 32'd0);

        // MEM stall during DONE: valid held, no relaunch.
        do_reset();
        n_go = 0; n_v = 0; n_ms = 0;
        for (int k = 0; k < 37; k++) begin
            cycle(0, 0, 0, 0, 1, (k >= 33 && k <= 35));
            if (k > 0) n_go += int'(cap_go);
            n_v += int'(cap_valid);
            if (cap_stall == 6'b011111) n_ms++;
        end
        check("no_relaunch", n_go, 0);
        check("valid_held_cycles", n_v, 4);
        check("mem_stall_cycles", n_ms, 3);
        cycle(0, 0, 0, 0, 0, 0);

        // Reset at BUSY count 10, then a fresh full divide.
        do_reset();
        for (int k = 0; k < 11; k++) cycle(0, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 1, 0);
        check("busy_at_cnt10", {31'd0, cap_busy}, 32'd1);
        cycle(0, 0, 0, 0, 0, 0);
        check("after_mid_reset", {28'd0, cap_go, cap_busy, cap_valid, |cap_stall}, 32'd0);
        n_go = 0; n_busy = 0;
        for (int k = 0; k < 34; k++) begin
            cycle(0, 0, 0, 0, 1, 0);
            if (k == 0) check("fresh_div_go", {31'd0, cap_go}, 32'd1);
            n_go += int'(cap_go); n_busy += int'(cap_busy);
            if (k == 33) check("fresh_div_valid", {31'd0, cap_valid}, 32'd1);
        end
        check("fresh_go_count", n_go, 1);
        check("fresh_busy_count", n_busy, 32);
        cycle(0, 0, 0, 0, 0, 0);

`ifdef PIPE_STALL_PERF_CNT_EN
        // One divide plus two load-use cycles.
        do_reset();
        for (int k = 0; k < 34; k++) cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("perf_div_literal", cap_pd, 32'd32);
        check("perf_loaduse_literal", cap_pl, 32'd2);
        check("perf_stall_literal", cap_ps, 32'd35);
`endif

        // Randomized run; ex_div_req is sticky to resemble a div sitting in EX.
        do_reset();
        dr_r = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(7) == 0) dr_r = ~dr_r;
            cycle(($urandom_range(299) == 0),
                  ($urandom_range(5) == 0), ($urandom_range(5) == 0),
                  ($urandom_range(9) == 0), dr_r, ($urandom_range(6) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall/sequencing controller for the 5-stage MIPS pipeline. It merges stall requests from IF (instruction SRAM wait), ID (load-use hazard), EX and MEM (data SRAM wait) into the per-stage `stall` bus that every pipeline register consumes. It also sequences the multi-cycle divider: it launches the divider, holds EX and the earlier stages for the full iteration count, and releases them in the cycle the quotient/remainder are valid.

## Interface
Parameters:
- `DIV_CYCLES`, default 32: divider iteration cycles, legal 2..63.
- `STALL_W`, default 6: stall bus width, one bit per boundary (PC, IF/ID, ID/EX, EX/MEM, MEM/WB, WB).

Ports:
- Reset is `rst`, synchronous, active-high; the clock is `clk`.
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `if_stallreq` in 1: instruction SRAM not ready.
- `id_stallreq` in 1: load-use hazard from decode.
- `ex_stallreq` in 1: generic EX hold.
- `ex_div_req` in 1: the EX instruction is div/divu. It stays high while that instruction sits in EX.
- `mem_stallreq` in 1: data SRAM not ready.
- `div_go` out 1: one-cycle launch pulse to the divider.
- `div_valid` out 1: divider result valid; EX captures HI/LO this cycle.
- `div_busy` out 1: FSM in BUSY.
- `stall` out STALL_W: bit i = 1 (Stop) freezes boundary i.

## Operation
- Stall encoding follows the existing rule that the highest requesting stage wins. Stop on bit i with NoStop on bit i+1 injects a bubble downstream.
  - MEM request: `6'b011111`.
  - EX request, or divider hold: `6'b001111`.
  - ID request: `6'b000111`.
  - IF request: `6'b000011`.
  - No request: `6'b000000`.
  - When several requests are active, the output is the bitwise OR of their patterns, which equals the highest-stage pattern.
- Divider FSM has three states: IDLE, BUSY, DONE.
  - IDLE → BUSY when `ex_div_req` & ~`mem_stallreq`. `div_go` = 1 in that same cycle, and the EX-level stall is asserted.
  - If `mem_stallreq` is high in IDLE while `ex_div_req` is high, no launch occurs. The MEM pattern already stalls EX.
  - BUSY: a 6-bit counter runs from 0 to DIV_CYCLES-1. The EX-level stall is held throughout. At count DIV_CYCLES-1 the FSM moves to DONE.
  - DONE: `div_valid` = 1 and the divider contributes no stall.
    - If `mem_stallreq` is also high, the FSM stays in DONE with `div_valid` held, because EX cannot advance.
    - Otherwise DONE → IDLE.
    - `ex_div_req` is ignored in DONE, which prevents a relaunch of the same instruction.
- `div_busy` = 1 exactly in BUSY.
- Reset at any point, including mid-division, forces IDLE, clears the counter, and drives all outputs to 0. The in-flight division is discarded; the pipeline registers are cleared by the same reset.

## Timing
- `stall` is combinational from the request inputs plus registered FSM state; there is no added latency. A request in cycle T freezes the pipeline registers at the edge ending T.
- Divider launched in cycle T:
  - BUSY spans cycles T+1 .. T+DIV_CYCLES.
  - DONE falls in cycle T+DIV_CYCLES+1.
  - EX is stalled for cycles T .. T+DIV_CYCLES, which is DIV_CYCLES+1 cycles.
  - The EX instruction advances at the edge ending DONE.
- Back-to-back divides: the second div reaches EX in the cycle after DONE and sees IDLE, so it launches in that cycle. There is no dead cycle beyond the DONE cycle.
- Reset values: `stall`=0, `div_go`=0, `div_valid`=0, `div_busy`=0, state IDLE, counter 0.

## Configuration
- Macro `PIPE_STALL_PERF_CNT_EN`.
- Defined: adds three 32-bit wrapping counters, each cleared by `rst`, and three outputs `perf_stall_cycles`, `perf_div_cycles`, `perf_loaduse_cycles` (each out 32).
  - `perf_stall_cycles` increments every cycle `stall[0]` = 1.
  - `perf_div_cycles` increments every BUSY cycle.
  - `perf_loaduse_cycles` increments when `id_stallreq` is the highest active request.
- Undefined: the counters and those ports are absent, and the stall/divider behaviour is identical.

## Structure
- Shared package `defines.vh` holds:
  - `StallBus` (=6) and the `Stop`/`NoStop` constants.
  - The four stall pattern constants `STALL_IF`, `STALL_ID`, `STALL_EX`, `STALL_MEM`.
  - The divider state encodings `DIV_IDLE`, `DIV_BUSY`, `DIV_DONE`.
- One sub-module is natural: `div_seq`, containing the FSM and counter, with outputs `div_go`, `div_valid`, `div_busy` and `div_hold`. The top level ORs `div_hold` into the EX request and builds the stall bus.

## Test plan
- Each request alone, no divider activity:
  - `if_stallreq` → `stall`=000011.
  - `id_stallreq` → 000111.
  - `ex_stallreq` → 001111.
  - `mem_stallreq` → 011111.
  - No request → 000000.
- `id_stallreq` and `mem_stallreq` together → 011111. `if_stallreq` and `ex_stallreq` together → 001111.
- DIV_CYCLES=32, `ex_div_req` held from T:
  - `div_go` pulses at T only.
  - `div_busy` is high for 32 cycles.
  - `div_valid` is high at T+33.
  - `stall`=001111 for T..T+32 and 000000 at T+33.
- `mem_stallreq` high during DONE for 3 cycles → `div_valid` held for 4 cycles and `stall`=011111 for 3 cycles. No relaunch (`div_go` stays 0).
- `rst` asserted at BUSY count 10 → next cycle all outputs are 0. With `ex_div_req` high after reset deasserts, a fresh `div_go` occurs and the full 32-cycle sequence repeats.
- `PIPE_STALL_PERF_CNT_EN` defined, one 32-cycle divide plus 2 load-use cycles:
  - `perf_div_cycles`=32.
  - `perf_loaduse_cycles`=2.
  - `perf_stall_cycles`=35.
